text_pixel_gen: RTL and testbench

- Text-mode pixel generator for the video peripheral.
- Consumes raw VGA timing (pixel counters, sync, display-enable) and fetches character/attribute words from the text buffer and glyph rows from the font ROM.
- Emits a per-pixel attribute byte plus a foreground/background select bit, delay-matched sync and enable.
- Sits directly upstream of the attribute-to-RGB colour mapper; attr_o feeds that mapper's attribute input.

---
 rtl/text_pixel_gen.sv | 164 ++++++++++++++++
 tb/tb_text_pixel_gen.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/text_pixel_gen.sv
// Text-mode pixel generator: VGA timing in, per-pixel attribute + fg/bg select out, 3-cycle latency.
// Optional hardware cursor underline enabled by defining TEXT_PIXEL_GEN_CURSOR_EN.
module text_pixel_gen #(
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int ADDR_W       = 12,
  parameter int BLINK_FRAMES = 16
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [9:0]        hcount_i,
  input  logic [9:0]        vcount_i,
  input  logic              de_i,
  input  logic              hsync_i,
  input  logic              vsync_i,
`ifdef TEXT_PIXEL_GEN_CURSOR_EN
  input  logic              cursor_en_i,
  input  logic [6:0]        cursor_col_i,
  input  logic [4:0]        cursor_row_i,
`endif
  output logic [ADDR_W-1:0] tbuf_addr_o,
  input  logic [15:0]       tbuf_rdata_i,
  output logic [11:0]       font_addr_o,
  input  logic [7:0]        font_rdata_i,
  output logic [7:0]        attr_o,
  output logic              pix_on_o,
  output logic              de_o,
  output logic              hsync_o,
  output logic              vsync_o
);

  localparam int CNT_W = $clog2(BLINK_FRAMES);

  if (BLINK_FRAMES < 2 || COLS < 1 || ROWS < 1) begin : g_bad_params
    $error("text_pixel_gen: BLINK_FRAMES must be >= 2 and COLS/ROWS >= 1");
  end

  logic [6:0]       col;
  logic [5:0]       row;

  logic             s1_de;
  logic             s1_hsync;
  logic             s1_vsync;
  logic [2:0]       s1_x;
  logic [3:0]       s1_y;

  logic             s2_de;
  logic             s2_hsync;
  logic             s2_vsync;
  logic [2:0]       s2_x;
  logic [7:0]       s2_attr;

  logic             vsync_q;
  logic             vsync_fall;
  logic [CNT_W-1:0] blink_cnt;
  logic             blink_phase;

  logic             glyph_bit;
  logic             pix_next;

  assign col = hcount_i[9:3];
  assign row = vcount_i[9:4];

  // Rows beyond the visible area simply wrap in the address space.
  assign tbuf_addr_o = de_i ? (ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col)) : '0;

  assign font_addr_o = {tbuf_rdata_i[7:0], s1_y};

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      s1_de    <= 1'b0;
      s1_hsync <= 1'b1;
      s1_vsync <= 1'b1;
      s1_x     <= '0;
      s1_y     <= '0;
    end else begin
      s1_de    <= de_i;
      s1_hsync <= hsync_i;
      s1_vsync <= vsync_i;
      s1_x     <= hcount_i[2:0];
      s1_y     <= vcount_i[3:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      s2_de    <= 1'b0;
      s2_hsync <= 1'b1;
      s2_vsync <= 1'b1;
      s2_x     <= '0;
      s2_attr  <= '0;
    end else begin
      s2_de    <= s1_de;
      s2_hsync <= s1_hsync;
      s2_vsync <= s1_vsync;
      s2_x     <= s1_x;
      s2_attr  <= tbuf_rdata_i[15:8];
    end
  end

  assign vsync_fall = vsync_q & ~vsync_i;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      vsync_q     <= 1'b1;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      vsync_q <= vsync_i;
      if (vsync_fall) begin
        if (blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign glyph_bit = font_rdata_i[3'd7 - s2_x];

`ifdef TEXT_PIXEL_GEN_CURSOR_EN
  logic cursor_hit;
  logic s1_cursor;
  logic s2_cursor;

  // Underline cursor on the bottom two scanlines of the selected cell, shown in the non-blink half.
  assign cursor_hit = cursor_en_i & (col == cursor_col_i) & (row == {1'b0, cursor_row_i})
                    & (vcount_i[3:0] >= 4'd14);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      s1_cursor <= 1'b0;
      s2_cursor <= 1'b0;
    end else begin
      s1_cursor <= cursor_hit;
      s2_cursor <= s1_cursor;
    end
  end

  assign pix_next = (glyph_bit & ~(s2_attr[7] & blink_phase) & s2_de)
                  ^ (s2_cursor & ~blink_phase & s2_de);
`else
  assign pix_next = glyph_bit & ~(s2_attr[7] & blink_phase) & s2_de;
`endif

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      attr_o   <= '0;
      pix_on_o <= 1'b0;
      de_o     <= 1'b0;
      hsync_o  <= 1'b1;
      vsync_o  <= 1'b1;
    end else begin
      attr_o   <= s2_de ? s2_attr : 8'h00;
      pix_on_o <= pix_next;
      de_o     <= s2_de;
      hsync_o  <= s2_hsync;
      vsync_o  <= s2_vsync;
    end
  end

endmodule

// File: tb/tb_text_pixel_gen.sv
// Bench for text_pixel_gen: random and raster stimulus against a per-pixel reference model
// that derives each output from the text/font memories and a frame count (BLINK_FRAMES=2).
module tb_text_pixel_gen;

  localparam int COLS         = 80;
  localparam int ADDR_W       = 12;
  localparam int BLINK_FRAMES = 2;

  logic              clk_i = 1'b0;
  logic              rstn_i;
  logic [9:0]        hcount_i;
  logic [9:0]        vcount_i;
  logic              de_i;
  logic              hsync_i;
  logic              vsync_i;
  logic [ADDR_W-1:0] tbuf_addr_o;
  logic [15:0]       tbuf_rdata_i;
  logic [11:0]       font_addr_o;
  logic [7:0]        font_rdata_i;
  logic [7:0]        attr_o;
  logic              pix_on_o;
  logic              de_o;
  logic              hsync_o;
  logic              vsync_o;
`ifdef TEXT_PIXEL_GEN_CURSOR_EN
  logic              cursor_en_i  = 1'b0;
  logic [6:0]        cursor_col_i = '0;
  logic [4:0]        cursor_row_i = '0;
`endif

  text_pixel_gen #(
    .COLS(COLS), .ROWS(30), .ADDR_W(ADDR_W), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .hcount_i(hcount_i), .vcount_i(vcount_i),
    .de_i(de_i), .hsync_i(hsync_i), .vsync_i(vsync_i),
`ifdef TEXT_PIXEL_GEN_CURSOR_EN
    .cursor_en_i(cursor_en_i), .cursor_col_i(cursor_col_i), .cursor_row_i(cursor_row_i),
`endif
    .tbuf_addr_o(tbuf_addr_o), .tbuf_rdata_i(tbuf_rdata_i),
    .font_addr_o(font_addr_o), .font_rdata_i(font_rdata_i),
    .attr_o(attr_o), .pix_on_o(pix_on_o), .de_o(de_o), .hsync_o(hsync_o), .vsync_o(vsync_o)
  );

  always #5 clk_i = ~clk_i;

  logic [15:0] tmem [4096];
  logic [7:0]  fmem [4096];

  always @(posedge clk_i) begin
    tbuf_rdata_i <= tmem[tbuf_addr_o];
    font_rdata_i <= fmem[font_addr_o];
  end

  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
    logic       fg;
    logic [7:0] attr;
  } pix_t;

  int   n_checks = 0;
  int   n_pass   = 0;
  bit   model_valid = 1'b0;
  pix_t exp_out;
  pix_t p_old;
  pix_t p_new;
  int   frames;
  logic vs_prev;
  logic [7:0] last_char;
  logic [3:0] last_y;

  function automatic pix_t idle_pix();
    pix_t p;
    p.de = 1'b0; p.hs = 1'b1; p.vs = 1'b1; p.fg = 1'b0; p.attr = 8'h00;
    return p;
  endfunction

  function automatic int cell_addr(input logic [9:0] h, input logic [9:0] v, input logic de);
    if (!de) return 0;
    return ((int'(v) / 16) * COLS + int'(h) / 8) % 4096;
  endfunction

  // Each pixel's result emerges two edges after it is sampled; blink uses frames seen by then.
  always @(posedge clk_i) begin
    int         a;
    logic [7:0] ch;
    logic [7:0] glyph;
    pix_t       cur;
    a  = cell_addr(hcount_i, vcount_i, de_i);
    ch = tmem[a][7:0];
    if (!rstn_i) begin
      exp_out = idle_pix();
      p_old   = idle_pix();
      p_new   = idle_pix();
      frames  = 0;
      vs_prev = 1'b1;
      last_y  = 4'd0;
    end else begin
      exp_out = p_old;
      if (p_old.attr[7] && ((frames / BLINK_FRAMES) % 2 == 1)) exp_out.fg = 1'b0;
      glyph    = fmem[{ch, vcount_i[3:0]}];
      cur.de   = de_i;
      cur.hs   = hsync_i;
      cur.vs   = vsync_i;
      cur.fg   = de_i & glyph[7 - (int'(hcount_i) % 8)];
      cur.attr = de_i ? tmem[a][15:8] : 8'h00;
      p_old = p_new;
      p_new = cur;
      if (vs_prev && !vsync_i) frames++;
      vs_prev = vsync_i;
      last_y  = vcount_i[3:0];
    end
    last_char   = ch;
    model_valid = 1'b1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
  endtask

  task automatic applyStimulus(input logic rst_n, input logic de, input logic [9:0] h,
                               input logic [9:0] v, input logic hs, input logic vs);
    @(negedge clk_i);
    if (model_valid) begin
      checkOutput("attr_o", 32'(attr_o), 32'(exp_out.attr));
      checkOutput("pix_on_o", 32'(pix_on_o), 32'(exp_out.fg));
      checkOutput("de_o", 32'(de_o), 32'(exp_out.de));
      checkOutput("hsync_o", 32'(hsync_o), 32'(exp_out.hs));
      checkOutput("vsync_o", 32'(vsync_o), 32'(exp_out.vs));
      checkOutput("tbuf_addr_o", 32'(tbuf_addr_o), 32'(cell_addr(hcount_i, vcount_i, de_i)));
      checkOutput("font_addr_o", 32'(font_addr_o), 32'({last_char, last_y}));
    end
    rstn_i   = rst_n;
    de_i     = de;
    hcount_i = h;
    vcount_i = v;
    hsync_i  = hs;
    vsync_i  = vs;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      tmem[i] = 16'($urandom);
      fmem[i] = 8'($urandom);
    end
    tmem[162] = 16'h1F41;
    fmem[12'h413] = 8'b1000_0001;
    tmem[85] = 16'h8F42;
    tmem[86] = 16'h0F42;
    fmem[12'h420] = 8'hFF;

    rstn_i = 1'b0; de_i = 1'b0; hcount_i = '0; vcount_i = '0; hsync_i = 1'b1; vsync_i = 1'b1;

    for (int i = 0; i < 5; i++)
      applyStimulus(1'b0, 1'($urandom), 10'($urandom), 10'($urandom), 1'($urandom), 1'($urandom));

    // Directed address and cell-boundary pixel sequence.
    applyStimulus(1'b1, 1'b1, 10'd17, 10'd35, 1'b1, 1'b1);
    #1 checkOutput("tbuf_addr_162", 32'(tbuf_addr_o), 32'd162);
    @(posedge clk_i);
    #1 checkOutput("font_addr_413", 32'(font_addr_o), 32'h413);
    for (int h = 16; h < 32; h++) applyStimulus(1'b1, 1'b1, 10'(h), 10'd35, 1'b1, 1'b1);

    // Blink cell (8F) beside a non-blinking cell (0F) over six frames.
    for (int f = 0; f < 6; f++) begin
      repeat (2) applyStimulus(1'b1, 1'b0, 10'd0, 10'd0, 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b1, 10'(40 + i), 10'd16, 1'b1, 1'b1);
    end

    // Short raster with blanking and hsync pulses.
    for (int ln = 0; ln < 3; ln++)
      for (int h = 0; h < 800; h++)
        applyStimulus(1'b1, 1'(h < 640), 10'(h), 10'(100 + ln), 1'(!(h >= 656 && h < 752)), 1'b1);

    // Random timing, including out-of-range rows and a mid-run reset.
    for (int i = 0; i < 2500; i++) begin
      applyStimulus(1'(!(i >= 1200 && i < 1203)), 1'($urandom_range(0, 3) != 0),
                    10'($urandom), 10'($urandom), 1'($urandom), 1'($urandom_range(0, 7) != 0));
    end

    repeat (4) applyStimulus(1'b1, 1'b0, 10'd0, 10'd0, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
